// File: rtl/ahb_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// ahb_bus_arbiter_if
//   Bundle of the per-master request/address/control/write-data signals and
//   the shared-bus outputs of the three-master AHB-Lite arbiter.
//
//   Modports:
//     slave  - arbiter view: master requests and HREADY in; grants,
//              ownership and the muxed shared bus out.
//     master - view of the masters / surrounding bus: the opposite directions.
//
//   Signals:
//     HBUSREQ_x, HLOCK_x         request and locked-sequence request per master
//     HADDR_x, HTRANS_x,         address-phase signals per master
//     HWRITE_x, HSIZE_x
//     HWDATA_x                   data-phase write data per master
//     HREADY                     bus-wide transfer complete
//     HGRANT_x                   registered grant, one-hot
//     HMASTER, HMASTLOCK         address-phase owner index and lock flag
//     HADDR, HTRANS, HWRITE,     shared address/control bus
//     HSIZE, HWDATA              shared write-data bus
// -----------------------------------------------------------------------------
interface ahb_bus_arbiter_if;
    logic        HBUSREQ_1, HBUSREQ_2, HBUSREQ_3;
    logic        HLOCK_1,   HLOCK_2,   HLOCK_3;
    logic [31:0] HADDR_1,   HADDR_2,   HADDR_3;
    logic [1:0]  HTRANS_1,  HTRANS_2,  HTRANS_3;
    logic        HWRITE_1,  HWRITE_2,  HWRITE_3;
    logic [2:0]  HSIZE_1,   HSIZE_2,   HSIZE_3;
    logic [31:0] HWDATA_1,  HWDATA_2,  HWDATA_3;
    logic        HREADY;

    logic        HGRANT_1,  HGRANT_2,  HGRANT_3;
    logic [1:0]  HMASTER;
    logic        HMASTLOCK;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;

    modport slave (
        input  HBUSREQ_1, HBUSREQ_2, HBUSREQ_3,
        input  HLOCK_1,   HLOCK_2,   HLOCK_3,
        input  HADDR_1,   HADDR_2,   HADDR_3,
        input  HTRANS_1,  HTRANS_2,  HTRANS_3,
        input  HWRITE_1,  HWRITE_2,  HWRITE_3,
        input  HSIZE_1,   HSIZE_2,   HSIZE_3,
        input  HWDATA_1,  HWDATA_2,  HWDATA_3,
        input  HREADY,
        output HGRANT_1,  HGRANT_2,  HGRANT_3,
        output HMASTER,   HMASTLOCK,
        output HADDR,     HTRANS,    HWRITE, HSIZE, HWDATA
    );

    modport master (
        output HBUSREQ_1, HBUSREQ_2, HBUSREQ_3,
        output HLOCK_1,   HLOCK_2,   HLOCK_3,
        output HADDR_1,   HADDR_2,   HADDR_3,
        output HTRANS_1,  HTRANS_2,  HTRANS_3,
        output HWRITE_1,  HWRITE_2,  HWRITE_3,
        output HSIZE_1,   HSIZE_2,   HSIZE_3,
        output HWDATA_1,  HWDATA_2,  HWDATA_3,
        output HREADY,
        input  HGRANT_1,  HGRANT_2,  HGRANT_3,
        input  HMASTER,   HMASTLOCK,
        input  HADDR,     HTRANS,    HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_bus_arbiter
//   Three-master AHB-Lite arbiter with address/control and write-data muxes.
//   Grants round-robin, never breaks a SEQ/BUSY burst or a locked sequence,
//   parks on DEFAULT_MASTER when nobody requests, and tracks the address- and
//   data-phase owners through the HREADY pipeline.
//
//   Parameters:
//     DEFAULT_MASTER  park / reset owner, 1..3
//   Ports:
//     HCLK     bus clock, rising edge
//     HRESETn  synchronous active-low reset
//     bus      ahb_bus_arbiter_if.slave (requests in, grants and shared bus out)
// -----------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 1
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] DEF_IDX    = 2'(DEFAULT_MASTER);
    localparam logic [2:0] DEF_ONEHOT = 3'(1 << (DEFAULT_MASTER - 1));

    // State: one-hot grant, address-phase owner, data-phase owner, lock flag.
    logic [2:0] grant_q,     grant_d;
    logic [1:0] hmaster_q,   hmaster_d;
    logic [1:0] downer_q,    downer_d;
    logic       hmastlock_q, hmastlock_d;

    logic [2:0] busreq;
    logic [2:0] hlock;
    logic [1:0] grant_idx;
    logic       grant_req;
    logic       grant_lock;
    logic [1:0] htrans_mux;
    logic       in_burst;

    assign busreq = {bus.HBUSREQ_3, bus.HBUSREQ_2, bus.HBUSREQ_1};
    assign hlock  = {bus.HLOCK_3,   bus.HLOCK_2,   bus.HLOCK_1};

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        case (oh)
            3'b001:  onehot_to_idx = 2'd1;
            3'b010:  onehot_to_idx = 2'd2;
            default: onehot_to_idx = 2'd3;
        endcase
    endfunction

    // Round-robin search starting just after the current owner; the owner
    // itself is the last candidate. Caller guarantees at least one request.
    function automatic logic [2:0] rr_pick(input logic [2:0] g, input logic [2:0] req);
        rr_pick = g;
        case (g)
            3'b001: begin
                if      (req[1]) rr_pick = 3'b010;
                else if (req[2]) rr_pick = 3'b100;
                else if (req[0]) rr_pick = 3'b001;
            end
            3'b010: begin
                if      (req[2]) rr_pick = 3'b100;
                else if (req[0]) rr_pick = 3'b001;
                else if (req[1]) rr_pick = 3'b010;
            end
            default: begin
                if      (req[0]) rr_pick = 3'b001;
                else if (req[1]) rr_pick = 3'b010;
                else if (req[2]) rr_pick = 3'b100;
            end
        endcase
    endfunction

    assign grant_idx  = onehot_to_idx(grant_q);
    assign grant_req  = |(busreq & grant_q);
    assign grant_lock = |(hlock  & grant_q);
    assign in_burst   = (htrans_mux == TRANS_SEQ) || (htrans_mux == TRANS_BUSY);

    // Next-state: everything holds while HREADY is low.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant_d     = grant_q;
        hmaster_d   = hmaster_q;
        downer_d    = downer_q;
        hmastlock_d = hmastlock_q;

        if (bus.HREADY) begin
            hmaster_d   = grant_idx;
            downer_d    = hmaster_q;
            hmastlock_d = grant_lock;

            if (grant_lock && grant_req) begin
                grant_d = grant_q;
            end else if (in_burst && (grant_idx == hmaster_q)) begin
                // Owner is mid-burst on the bus: only it may continue.
                grant_d = grant_q;
            end else if (|busreq) begin
                grant_d = rr_pick(grant_q, busreq);
            end else begin
                grant_d = DEF_ONEHOT;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        // NOTE: reset is sampled on the clock edge only, so it sits inside the
        // clocked branch rather than in the sensitivity list.
        if (!HRESETn) begin
            grant_q     <= DEF_ONEHOT;
            hmaster_q   <= DEF_IDX;
            downer_q    <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others (D takes the old HMASTER).
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            downer_q    <= downer_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    // Address/control mux follows the address-phase owner.
    always_comb begin
        case (hmaster_q)
            2'd2: begin
                htrans_mux = bus.HTRANS_2;
                bus.HADDR  = bus.HADDR_2;
                bus.HWRITE = bus.HWRITE_2;
                bus.HSIZE  = bus.HSIZE_2;
            end
            2'd3: begin
                htrans_mux = bus.HTRANS_3;
                bus.HADDR  = bus.HADDR_3;
                bus.HWRITE = bus.HWRITE_3;
                bus.HSIZE  = bus.HSIZE_3;
            end
            default: begin
                htrans_mux = bus.HTRANS_1;
                bus.HADDR  = bus.HADDR_1;
                bus.HWRITE = bus.HWRITE_1;
                bus.HSIZE  = bus.HSIZE_1;
            end
        endcase
    end

    // Write data follows the data-phase owner, one HREADY stage behind.
    always_comb begin
        case (downer_q)
            2'd2:    bus.HWDATA = bus.HWDATA_2;
            2'd3:    bus.HWDATA = bus.HWDATA_3;
            default: bus.HWDATA = bus.HWDATA_1;
        endcase
    end

    assign bus.HTRANS    = htrans_mux;
    assign bus.HGRANT_1  = grant_q[0];
    assign bus.HGRANT_2  = grant_q[1];
    assign bus.HGRANT_3  = grant_q[2];
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
module tb_ahb_bus_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [31:0] AD1 = 32'h1000_0010;
    localparam logic [31:0] AD2 = 32'h2000_0020;
    localparam logic [31:0] AD3 = 32'h3000_0030;
    localparam logic [31:0] WD1 = 32'hAAAA_0001;
    localparam logic [31:0] WD2 = 32'hBBBB_0002;
    localparam logic [31:0] WD3 = 32'hCCCC_0003;

    logic HCLK;
    logic HRESETn;
    int   n_checks;
    int   n_fail;

    ahb_bus_arbiter_if bus ();

    ahb_bus_arbiter #(.DEFAULT_MASTER(1)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [2:0] gnt;
    assign gnt = {bus.HGRANT_3, bus.HGRANT_2, bus.HGRANT_1};

    function automatic logic [2:0] oh(input int i);
        oh = 3'b000;
        oh[i-1] = 1'b1;
    endfunction

    function automatic logic [31:0] ad(input int i);
        case (i)
            2:       ad = AD2;
            3:       ad = AD3;
            default: ad = AD1;
        endcase
    endfunction

    function automatic logic [31:0] wd(input int i);
        case (i)
            2:       wd = WD2;
            3:       wd = WD3;
            default: wd = WD1;
        endcase
    endfunction

    // {HWRITE, HSIZE} driven by each master.
    function automatic logic [3:0] ctl(input int i);
        case (i)
            2:       ctl = {1'b0, 3'd1};
            3:       ctl = {1'b1, 3'd2};
            default: ctl = {1'b1, 3'd0};
        endcase
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.HBUSREQ_1 = 1'b0; bus.HBUSREQ_2 = 1'b0; bus.HBUSREQ_3 = 1'b0;
        bus.HLOCK_1   = 1'b0; bus.HLOCK_2   = 1'b0; bus.HLOCK_3   = 1'b0;
        bus.HTRANS_1  = T_IDLE; bus.HTRANS_2 = T_IDLE; bus.HTRANS_3 = T_IDLE;
        bus.HREADY    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESETn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK} !== {3'b001, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b hmaster=%0d lock=%b, want gnt=001 hmaster=1 lock=0",
                     gnt, bus.HMASTER, bus.HMASTLOCK);
        end
        n_checks++;
        if ({bus.HWDATA, bus.HADDR} !== {WD1, AD1}) begin
            n_fail++;
            $display("FAIL reset_mux: got hwdata=%h haddr=%h, want hwdata=%h haddr=%h",
                     bus.HWDATA, bus.HADDR, WD1, AD1);
        end
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({gnt, bus.HMASTER, bus.HMASTLOCK, bus.HWDATA} !== {3'b001, 2'd1, 1'b0, WD1}) begin
                n_fail++;
                $display("FAIL park_cycle%0d: got gnt=%b hmaster=%0d lock=%b hwdata=%h, want gnt=001 hmaster=1 lock=0 hwdata=%h",
                         i, gnt, bus.HMASTER, bus.HMASTLOCK, bus.HWDATA, WD1);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_g;
        int exp_hm;
        int exp_d;
        do_reset();
        bus.HBUSREQ_1 = 1'b1; bus.HBUSREQ_2 = 1'b1; bus.HBUSREQ_3 = 1'b1;
        bus.HTRANS_1 = T_NONSEQ; bus.HTRANS_2 = T_NONSEQ; bus.HTRANS_3 = T_NONSEQ;
        exp_g = 1; exp_hm = 1; exp_d = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            // Grant rotates 2,3,1,...; HMASTER lags grant, D lags HMASTER.
            exp_d  = exp_hm;
            exp_hm = exp_g;
            exp_g  = (exp_g % 3) + 1;
            n_checks++;
            if ({gnt, bus.HMASTER, bus.HWDATA} !== {oh(exp_g), 2'(exp_hm), wd(exp_d)}) begin
                n_fail++;
                $display("FAIL rr_step%0d: got gnt=%b hmaster=%0d hwdata=%h, want gnt=%b hmaster=%0d hwdata=%h",
                         i, gnt, bus.HMASTER, bus.HWDATA, oh(exp_g), exp_hm, wd(exp_d));
            end
            n_checks++;
            if ({bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HTRANS} !== {ad(exp_hm), ctl(exp_hm), T_NONSEQ}) begin
                n_fail++;
                $display("FAIL rr_addr%0d: got haddr=%h ctl=%b htrans=%b, want haddr=%h ctl=%b htrans=10",
                         i, bus.HADDR, {bus.HWRITE, bus.HSIZE}, bus.HTRANS, ad(exp_hm), ctl(exp_hm));
            end
        end
    endtask

    task automatic test_burst_hold();
        logic [2:0] exp_g [8];
        int         exp_hm [8];
        exp_g  = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
        exp_hm = '{1, 2, 2, 2, 2, 2, 2, 3};
        do_reset();
        bus.HBUSREQ_2 = 1'b1;
        bus.HTRANS_2  = T_NONSEQ;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({gnt, bus.HMASTER} !== {exp_g[i], 2'(exp_hm[i])}) begin
                n_fail++;
                $display("FAIL burst_edge%0d: got gnt=%b hmaster=%0d, want gnt=%b hmaster=%0d",
                         i + 1, gnt, bus.HMASTER, exp_g[i], exp_hm[i]);
            end
            case (i)
                2: begin bus.HTRANS_2 = T_SEQ; bus.HBUSREQ_3 = 1'b1; end
                3: bus.HBUSREQ_2 = 1'b0;
                5: begin bus.HTRANS_2 = T_IDLE; bus.HTRANS_3 = T_NONSEQ; end
                default: ;
            endcase
        end
    endtask

    task automatic test_locked();
        do_reset();
        bus.HBUSREQ_3 = 1'b1;
        bus.HLOCK_3   = 1'b1;
        bus.HTRANS_3  = T_NONSEQ;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK} !== {3'b100, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_grant: got gnt=%b hmaster=%0d lock=%b, want gnt=100 hmaster=1 lock=0",
                     gnt, bus.HMASTER, bus.HMASTLOCK);
        end
        bus.HBUSREQ_1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({gnt, bus.HMASTER, bus.HMASTLOCK} !== {3'b100, 2'd3, 1'b1}) begin
                n_fail++;
                $display("FAIL lock_hold%0d: got gnt=%b hmaster=%0d lock=%b, want gnt=100 hmaster=3 lock=1",
                         i, gnt, bus.HMASTER, bus.HMASTLOCK);
            end
        end
        bus.HLOCK_3 = 1'b0;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK} !== {3'b001, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_release: got gnt=%b hmaster=%0d lock=%b, want gnt=001 hmaster=3 lock=0",
                     gnt, bus.HMASTER, bus.HMASTLOCK);
        end
        bus.HBUSREQ_3 = 1'b0;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK} !== {3'b001, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_after: got gnt=%b hmaster=%0d lock=%b, want gnt=001 hmaster=1 lock=0",
                     gnt, bus.HMASTER, bus.HMASTLOCK);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        bus.HBUSREQ_2 = 1'b1;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HWDATA} !== {3'b010, 2'd1, WD1}) begin
            n_fail++;
            $display("FAIL wait_pre: got gnt=%b hmaster=%0d hwdata=%h, want gnt=010 hmaster=1 hwdata=%h",
                     gnt, bus.HMASTER, bus.HWDATA, WD1);
        end
        // A new request during the stall must be ignored until HREADY returns.
        bus.HREADY    = 1'b0;
        bus.HBUSREQ_3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({gnt, bus.HMASTER, bus.HWDATA, bus.HADDR} !== {3'b010, 2'd1, WD1, AD1}) begin
                n_fail++;
                $display("FAIL wait_frozen%0d: got gnt=%b hmaster=%0d hwdata=%h haddr=%h, want gnt=010 hmaster=1 hwdata=%h haddr=%h",
                         i, gnt, bus.HMASTER, bus.HWDATA, bus.HADDR, WD1, AD1);
            end
        end
        bus.HREADY = 1'b1;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HWDATA, bus.HADDR} !== {3'b100, 2'd2, WD1, AD2}) begin
            n_fail++;
            $display("FAIL wait_handover: got gnt=%b hmaster=%0d hwdata=%h haddr=%h, want gnt=100 hmaster=2 hwdata=%h haddr=%h",
                     gnt, bus.HMASTER, bus.HWDATA, bus.HADDR, WD1, AD2);
        end
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HWDATA} !== {3'b010, 2'd3, WD2}) begin
            n_fail++;
            $display("FAIL wait_data: got gnt=%b hmaster=%0d hwdata=%h, want gnt=010 hmaster=3 hwdata=%h",
                     gnt, bus.HMASTER, bus.HWDATA, WD2);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.HBUSREQ_2 = 1'b1;
        bus.HLOCK_2   = 1'b1;
        bus.HTRANS_2  = T_NONSEQ;
        tick();
        tick();
        bus.HTRANS_2 = T_SEQ;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK, bus.HTRANS} !== {3'b010, 2'd2, 1'b1, T_SEQ}) begin
            n_fail++;
            $display("FAIL midburst_pre: got gnt=%b hmaster=%0d lock=%b htrans=%b, want gnt=010 hmaster=2 lock=1 htrans=11",
                     gnt, bus.HMASTER, bus.HMASTLOCK, bus.HTRANS);
        end
        HRESETn = 1'b0;
        tick();
        n_checks++;
        if ({gnt, bus.HMASTER, bus.HMASTLOCK, bus.HWDATA} !== {3'b001, 2'd1, 1'b0, WD1}) begin
            n_fail++;
            $display("FAIL midburst_reset: got gnt=%b hmaster=%0d lock=%b hwdata=%h, want gnt=001 hmaster=1 lock=0 hwdata=%h",
                     gnt, bus.HMASTER, bus.HMASTLOCK, bus.HWDATA, WD1);
        end
        HRESETn = 1'b1;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        HRESETn  = 1'b0;
        idle_inputs();
        bus.HADDR_1  = AD1; bus.HADDR_2  = AD2; bus.HADDR_3  = AD3;
        bus.HWDATA_1 = WD1; bus.HWDATA_2 = WD2; bus.HWDATA_3 = WD3;
        {bus.HWRITE_1, bus.HSIZE_1} = ctl(1);
        {bus.HWRITE_2, bus.HSIZE_2} = ctl(2);
        {bus.HWRITE_3, bus.HSIZE_3} = ctl(3);

        test_reset();
        test_round_robin();
        test_burst_hold();
        test_locked();
        test_wait_states();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Three-master AHB-Lite bus arbiter and address/write-data multiplexer. It sits between the bus masters and the address decoder / slave-response multiplexer. It grants the shared bus round-robin, keeps bursts and locked sequences intact, and parks on a default master when idle. It drives the address-phase and data-phase owner indices and routes each master's address, control and write data onto the shared bus, following the transfer pipeline via the bus-wide HREADY.

## Interface
- DEFAULT_MASTER, 1: master index (1..3) parked on when no request is pending; also the reset owner.
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  synchronous, active-low reset, sampled on rising HCLK.
- HBUSREQ_1, HBUSREQ_2, HBUSREQ_3  in  1 each  bus request per master.
- HLOCK_1, HLOCK_2, HLOCK_3  in  1 each  locked-sequence request per master.
- HADDR_1, HADDR_2, HADDR_3  in  32 each  master address.
- HTRANS_1, HTRANS_2, HTRANS_3  in  2 each  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE_1, HWRITE_2, HWRITE_3  in  1 each  write/read.
- HSIZE_1, HSIZE_2, HSIZE_3  in  3 each  transfer size.
- HWDATA_1, HWDATA_2, HWDATA_3  in  32 each  write data.
- HREADY  in  1  bus-wide transfer-complete, taken from the slave-response multiplexer.
- HGRANT_1, HGRANT_2, HGRANT_3  out  1 each  registered grant, exactly one high at all times.
- HMASTER  out  2  address-phase owner index (1..3), registered.
- HMASTLOCK  out  1  registered; current address-phase transfer is part of a locked sequence.
- HADDR  out  32  combinational mux of HADDR_x selected by HMASTER.
- HTRANS  out  2  combinational mux of HTRANS_x selected by HMASTER.
- HWRITE  out  1  combinational mux of HWRITE_x selected by HMASTER.
- HSIZE  out  3  combinational mux of HSIZE_x selected by HMASTER.
- HWDATA  out  32  combinational mux of HWDATA_x selected by the data-phase owner.

## Operation
- **State registers:** one-hot grant owner G, HMASTER (address-phase owner), D (data-phase owner, internal, 2 bits), HMASTLOCK.
- **Reset** (HRESETn=0 at an edge):
  - HGRANT of DEFAULT_MASTER = 1, other HGRANT = 0.
  - HMASTER = DEFAULT_MASTER, D = DEFAULT_MASTER, HMASTLOCK = 0.
  - Reset overrides everything, including mid-burst and mid-lock.
- **Freeze:** with HREADY=0, G, HMASTER, D and HMASTLOCK all hold. Request changes are ignored until HREADY=1.
- **Re-arbitration:** at an edge with HREADY=1, the next G is chosen by the first applicable rule:
  1. **Lock hold:** the granted master has HLOCK_x=1 and HBUSREQ_x=1 → keep G.
  2. **Burst hold:** muxed HTRANS is SEQ or BUSY and the granted master equals HMASTER → keep G. Bursts are never broken by the arbiter.
  3. **Round-robin:** search the masters starting at G+1 and wrapping 3→1. Grant the first with HBUSREQ=1. The current owner is the last candidate, so it keeps the bus only if no other master requests.
  4. **Park:** no HBUSREQ asserted → grant DEFAULT_MASTER.
- **Pipeline advance**, same HREADY=1 edge:
  - HMASTER ← index(G) (the old G).
  - D ← HMASTER (the old HMASTER).
  - HMASTLOCK ← HLOCK of the old-G master.
- The output muxes are purely combinational; an index outside 1..3 never occurs after reset.

## Timing
- Grant latency: a request first seen at HREADY-edge k drives HGRANT at edge k.
- HMASTER switches at the next HREADY=1 edge (k+1). That master's write data appears on HWDATA after one more HREADY=1 edge (k+2).
- Each wait state (HREADY=0) stretches every stage by exactly one cycle.
- **Simultaneous requests:** a single edge grants exactly one master, chosen by the round-robin order.
- Dropping HBUSREQ mid-burst does not release the bus until HTRANS leaves SEQ/BUSY.
- Deasserting HLOCK releases the lock at the next HREADY=1 edge.
- No combinational path from any HBUSREQ or HLOCK input to HGRANT or HMASTER.

## Test plan
- **Reset/park:** hold HRESETn=0 for 2 cycles, no requests → HGRANT_1=1, HMASTER=1, HMASTLOCK=0, HWDATA=HWDATA_1; stays parked for 10 cycles.
- **Round-robin fairness:** HBUSREQ_1..3 held high, HTRANS=NONSEQ every cycle, HREADY=1 → grant sequence 2,3,1,2,3,1…; HMASTER lags HGRANT by one cycle, D lags HMASTER by one cycle.
- **Burst hold:** master 2 granted, issues NONSEQ then 3×SEQ while master 3 requests → HGRANT_2 held through the last SEQ; HGRANT_3 asserts on the edge after the final SEQ.
- **Locked sequence:** master 3 with HLOCK_3=1, HBUSREQ_1=1 → HGRANT_3 held, HMASTLOCK=1 one edge later; drop HLOCK_3 → HGRANT_1 at the next HREADY edge.
- **Wait states:** HREADY=0 for 3 cycles during a grant change from 1→2 → HGRANT, HMASTER and HWDATA source all frozen; the handover completes on the first HREADY=1 edge.
- **Reset mid-burst:** HRESETn=0 during master 2 SEQ → next edge HGRANT_1=1, HMASTER=1, HMASTLOCK=0.
